lead_run_expand: RTL and testbench
==================================

Name: lead_run_expand

Overview:
- Inverse of the EX-stage leading-one/leading-zero byte counter: converts a run length and bit value into a 32-bit word.
- Output word has exactly `count` leading copies of `bit` (MSB first); all remaining bits are the opposite value (thermometer pattern).
- Used by the EX stage for INS/EXT mask generation and as an operand generator for CLO/CLZ self-test.
- Multi-cycle: builds the word one byte per cycle, MSB byte first, behind valid/ready handshakes.

Parameters:
- None. Width is fixed at 32 bits (4 bytes); count width is fixed at 6 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort of the in-flight operation (pipeline flush)
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at a clock edge
- in_count  in  6  requested run length, 0..63; values >32 saturate to 32
- in_bit  in  1  value of the leading run
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  32  generated pattern
- out_count  out  6  saturated count echoed with the result
- check_err  out  1  self-check flag (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, out_valid=0, out_data=0, out_count=0, check_err=0, byte index=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch sat_count=min(in_count,32) and the bit value, set index=0, go to RUN.
  - RUN: in_ready=0. Each cycle write byte k (k=0 is bits 31:24, k=3 is bits 7:0), then increment k. After k=3 is written, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE and drop out_valid.
- in_ready is combinational and equals (state==IDLE). No new request is accepted in DONE, including the same cycle out_ready is high.
- Byte k generation:
  - r = sat_count - 8k, clipped to the range 0..8.
  - Byte = r MSBs equal to bit, then 8-r bits equal to ~bit.
  - r=8 gives {8{bit}}; r=0 gives {8{~bit}}.
- Latency: request accepted at edge T; out_valid is high from edge T+5. That is 4 RUN edges plus the DONE entry edge, so 5 cycles total.
- out_data and out_count hold stable throughout DONE regardless of out_ready. out_data bytes not yet written in RUN hold stale values; they are not observable because out_valid=0.
- Boundary cases:
  - count 0 → word is all ~bit.
  - count 32..63 → word is all bit; out_count=32.
  - count 8/16/24 → byte-aligned boundary; the next byte starts with ~bit.
- Flush:
  - Any state → IDLE on the next edge; out_valid=0, out_data=0, out_count=0.
  - A request presented in the same cycle as flush is not accepted.
  - flush has priority over out_ready and in_valid.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded.

Optional Feature:
- Macro: LEAD_RUN_EXPAND_CHECK_EN
- Defined:
  - In DONE, recount the leading bit-valued run of out_data combinationally and compare it with out_count.
  - On mismatch, set check_err; it is sticky until rst.
  - The recount reuses per-byte leading-count logic, combined MSB byte first.
- Undefined: no checker logic; check_err is tied to 0.

Decomposition:
- Shared EX-stage package holds:
  - state encoding (IDLE, RUN, DONE)
  - BYTE_W=8
  - WORD_BYTES=4
  - COUNT_MAX=32
- One combinational sub-module, lead_run_byte_gen: inputs rem_count[3:0] (0..8) and bit; output byte[7:0]. It is instantiated once and muxed by the byte index.

Test Plan:
- count=5, bit=1, out_ready=1 → 0xF8000000, out_count=5, out_valid exactly 5 cycles after acceptance; check_err=0.
- count=12, bit=0 → 0x000FFFFF; count=0, bit=0 → 0xFFFFFFFF; count=0, bit=1 → 0x00000000.
- count=40, bit=0 → 0x00000000, out_count=32; count=32, bit=1 → 0xFFFFFFFF; count=8, bit=1 → 0xFF000000.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → out_data stable and in_ready=0 throughout; a new in_valid is not accepted until one cycle after the out_ready handshake.
- flush asserted at the 2nd RUN cycle with in_valid high → IDLE next cycle, out_valid never rises, in_ready=1; the next request (count=24, bit=1) → 0xFFFFFF00.
- Assert rst asynchronously mid-RUN → all outputs 0 immediately; with LEAD_RUN_EXPAND_CHECK_EN, a forced out_data corruption in DONE → check_err=1, and it stays 1 until rst.

Source files
------------

// File: rtl/lead_run_expand_pkg.sv
// Shared EX-stage definitions for the lead-run expander: state encoding, geometry
// and helpers for count saturation and per-byte leading-run counting.
package lead_run_expand_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned COUNT_MAX  = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic logic [5:0] sat_count(input logic [5:0] count);
    return (count > 6'(COUNT_MAX)) ? 6'(COUNT_MAX) : count;
  endfunction

  // Number of leading (MSB-first) bits of data equal to run_bit, 0..8.
  function automatic logic [3:0] lead_count_byte(input logic [7:0] data, input logic run_bit);
    logic [3:0] n;
    logic       stop;
    n    = '0;
    stop = 1'b0;
    for (int i = BYTE_W - 1; i >= 0; i--) begin
      if (!stop && (data[i] == run_bit)) begin
        n = n + 4'd1;
      end else begin
        stop = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/lead_run_expand_byte_gen.sv
// One thermometer byte: rem_count MSBs equal to run_bit, the rest its complement.
module lead_run_byte_gen (
  input  logic [3:0] rem_count,
  input  logic       run_bit,
  output logic [7:0] byte_data
);

  logic [7:0] mask;

  // Shifting by 8 empties the register, so rem_count=8 yields an all-ones mask.
  always_comb begin
    mask      = ~(8'hFF >> rem_count);
    byte_data = run_bit ? mask : ~mask;
  end

endmodule

// File: rtl/lead_run_expand.sv
// Run-length to thermometer-word expander, one byte per cycle, MSB byte first.
// Optional self-check enabled by defining LEAD_RUN_EXPAND_CHECK_EN.
module lead_run_expand
  import lead_run_expand_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_count,
  input  logic        in_bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_count,
  output logic        check_err
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        run_bit_q, run_bit_d;
  logic [31:0] out_data_q, out_data_d;
  logic [5:0]  out_count_q, out_count_d;

  logic [5:0]  base;
  logic [3:0]  rem_count;
  logic [7:0]  gen_byte;

  // Bits of the run still owed to byte idx: clip(count - 8*idx, 0, 8).
  always_comb begin
    base = {idx_q[1:0], 3'b000};
    if (out_count_q <= base) begin
      rem_count = 4'd0;
    end else if (out_count_q >= base + 6'd8) begin
      rem_count = 4'd8;
    end else begin
      rem_count = 4'(out_count_q - base);
    end
  end

  lead_run_byte_gen u_byte_gen (
    .rem_count (rem_count),
    .run_bit   (run_bit_q),
    .byte_data (gen_byte)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_bit_d   = run_bit_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (flush) begin
      state_d     = StIdle;
      idx_d       = '0;
      out_data_d  = '0;
      out_count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            out_count_d = sat_count(in_count);
            run_bit_d   = in_bit;
            idx_d       = '0;
            state_d     = StRun;
          end
        end
        StRun: begin
          // idx reaches 4 on the edge that writes the last byte; DONE follows one edge later.
          if (idx_q == 3'(WORD_BYTES)) begin
            state_d = StDone;
          end else begin
            case (idx_q[1:0])
              2'd0:    out_data_d[31:24] = gen_byte;
              2'd1:    out_data_d[23:16] = gen_byte;
              2'd2:    out_data_d[15:8]  = gen_byte;
              default: out_data_d[7:0]   = gen_byte;
            endcase
            idx_d = idx_q + 3'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      run_bit_q   <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      run_bit_q   <= run_bit_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

`ifdef LEAD_RUN_EXPAND_CHECK_EN
  logic       check_err_q;
  logic [5:0] recount;
  logic       mismatch;

  // Recount from the visible word, extending across bytes only while each byte is full.
  always_comb begin
    logic       full;
    logic [3:0] c;
    recount = '0;
    full    = 1'b1;
    for (int k = 0; k < int'(WORD_BYTES); k++) begin
      c = lead_count_byte(out_data[31 - 8 * k -: 8], run_bit_q);
      if (full) begin
        recount = recount + 6'(c);
        full    = (c == 4'd8);
      end
    end
    mismatch = (state_q == StDone) && (recount != out_count_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      check_err_q <= 1'b0;
    end else if (mismatch) begin
      check_err_q <= 1'b1;
    end
  end

  assign check_err = check_err_q;
`else
  assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_lead_run_expand.sv
// Self-checking bench for lead_run_expand: directed cases, random requests against a
// bit-level reference model, backpressure, flush and asynchronous reset.
module tb_lead_run_expand;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_count;
  logic        in_bit;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_count;
  logic        check_err;

  int errors = 0;
  int checks = 0;

  lead_run_expand dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .check_err (check_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
    $fatal(1);
  end

  function automatic int model_count(input int cnt);
    return (cnt > 32) ? 32 : cnt;
  endfunction

  // Bit i from the MSB equals b while i < saturated count, ~b afterwards.
  function automatic logic [31:0] model_word(input int cnt, input logic b);
    logic [31:0] w;
    int s;
    s = model_count(cnt);
    for (int i = 0; i < 32; i++) w[31 - i] = (i < s) ? b : ~b;
    return w;
  endfunction

  // Present one request from an IDLE cycle and wait for out_valid; lat=-1 on timeout.
  task automatic issue(input int cnt, input logic b, output logic [31:0] data,
                       output logic [5:0] ocnt, output int lat);
    in_valid  = 1'b1;
    in_count  = 6'(cnt);
    in_bit    = b;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    data = out_data;
    ocnt = out_count;
  endtask

  task automatic finish_req();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_count = '0; in_bit = 1'b0; out_ready = 1'b0;
    #12;
    checks++;
    if ({out_valid, out_data, out_count, check_err, in_ready} !== {1'b0, 32'h0, 6'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h count=%0d err=%b ready=%b, want 0/0/0/0/1",
               out_valid, out_data, out_count, check_err, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int          cnts[9] = '{5, 12, 0, 0, 40, 32, 8, 16, 24};
    logic        bits[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] exps[9] = '{32'hF800_0000, 32'h000F_FFFF, 32'hFFFF_FFFF, 32'h0000_0000,
                             32'h0000_0000, 32'hFFFF_FFFF, 32'hFF00_0000, 32'h0000_FFFF,
                             32'h0000_00FF};
    int          ecnt[9] = '{5, 12, 0, 0, 32, 32, 8, 16, 24};
    logic [31:0] d;
    logic [5:0]  c;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      issue(cnts[i], bits[i], d, c, lat);
      checks++;
      if (lat != 5) begin
        errors++;
        $display("FAIL directed latency #%0d: got %0d cycles, want 5", i, lat);
      end
      checks++;
      if (d !== exps[i] || c !== 6'(ecnt[i])) begin
        errors++;
        $display("FAIL directed word #%0d: got %h/%0d, want %h/%0d", i, d, c, exps[i], ecnt[i]);
      end
      checks++;
      if (check_err !== 1'b0) begin
        errors++;
        $display("FAIL directed check_err #%0d: got %b, want 0", i, check_err);
      end
      finish_req();
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [5:0]  c;
    int          lat, cnt, hold;
    logic        b;
    for (int i = 0; i < 40; i++) begin
      cnt  = int'($urandom_range(0, 63));
      b    = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(0, 3));
      issue(cnt, b, d, c, lat);
      repeat (hold) begin
        @(posedge clk); #1;
      end
      checks++;
      if (lat != 5 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL random latency #%0d: lat=%0d valid=%b, want 5/1", i, lat, out_valid);
      end
      checks++;
      if (out_data !== model_word(cnt, b) || out_count !== 6'(model_count(cnt))) begin
        errors++;
        $display("FAIL random word #%0d cnt=%0d bit=%b: got %h/%0d, want %h/%0d", i, cnt, b,
                 out_data, out_count, model_word(cnt, b), model_count(cnt));
      end
      finish_req();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [5:0]  c;
    int          lat;
    issue(20, 1'b1, d, c, lat);
    checks++;
    if (d !== 32'hFFFF_F000) begin
      errors++;
      $display("FAIL backpressure first word: got %h, want fffff000", d);
    end
    in_valid = 1'b1; in_count = 6'd3; in_bit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_data !== d || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure hold %0d: data=%h ready=%b valid=%b, want %h/0/1",
                 i, out_data, in_ready, out_valid, d);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake edge: valid=%b ready=%b, want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL next accept: ready=%b, want 0 one cycle after handshake", in_ready);
    end
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 5 || out_data !== model_word(3, 1'b0) || out_count !== 6'd3) begin
      errors++;
      $display("FAIL second word: lat=%0d got %h/%0d, want 5 %h/3", lat, out_data, out_count,
               model_word(3, 1'b0));
    end
    finish_req();
  endtask

  task automatic test_flush();
    logic [31:0] d;
    logic [5:0]  c;
    int          lat;
    logic        rose;
    in_valid = 1'b1; in_count = 6'd17; in_bit = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_data, out_count} !== {1'b1, 1'b0, 32'h0, 6'h0}) begin
      errors++;
      $display("FAIL flush: ready=%b valid=%b data=%h count=%0d, want 1/0/0/0",
               in_ready, out_valid, out_data, out_count);
    end
    rose = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) rose = 1'b1;
    end
    checks++;
    if (rose !== 1'b0) begin
      errors++;
      $display("FAIL flush valid: out_valid rose=%b, want 0", rose);
    end
    issue(24, 1'b1, d, c, lat);
    checks++;
    if (lat != 5 || d !== 32'hFFFF_FF00 || c !== 6'd24) begin
      errors++;
      $display("FAIL after flush: lat=%0d got %h/%0d, want 5 ffffff00/24", lat, d, c);
    end
    finish_req();
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic [5:0]  c;
    int          lat;
    in_valid = 1'b1; in_count = 6'd20; in_bit = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, out_count, check_err} !== {1'b0, 32'h0, 6'h0, 1'b0}) begin
      errors++;
      $display("FAIL async reset: valid=%b data=%h count=%0d err=%b, want all 0",
               out_valid, out_data, out_count, check_err);
    end
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(5, 1'b1, d, c, lat);
    checks++;
    if (lat != 5 || d !== 32'hF800_0000) begin
      errors++;
      $display("FAIL after reset: lat=%0d got %h, want 5 f8000000", lat, d);
    end
    finish_req();
  endtask

`ifdef LEAD_RUN_EXPAND_CHECK_EN
  task automatic test_check_err();
    logic [31:0] d;
    logic [5:0]  c;
    int          lat;
    issue(5, 1'b1, d, c, lat);
    force dut.out_data = d ^ 32'h0400_0000;
    @(posedge clk); #1;
    release dut.out_data;
    checks++;
    if (check_err !== 1'b1) begin
      errors++;
      $display("FAIL check_err set: got %b, want 1", check_err);
    end
    finish_req();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (check_err !== 1'b1) begin
      errors++;
      $display("FAIL check_err sticky: got %b, want 1", check_err);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (check_err !== 1'b0) begin
      errors++;
      $display("FAIL check_err clear: got %b, want 0", check_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef LEAD_RUN_EXPAND_CHECK_EN
    test_check_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
